vend_ctrl: RTL and testbench

Transaction controller that sequences the vending datapath: accumulates coin credit, accepts a product selection against a parameterised price table, drives a req/ack handshake to the dispense mechanism, then returns change as 5-unit pulses. It sits between the coin acceptor / keypad front end and the dispenser motor driver. It replaces ad-hoc per-product FSMs with a single credit register and price lookup.

---
 rtl/vend_ctrl.sv | 173 +++++++++++++++++
 tb/tb_vend_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vend_ctrl.sv
// Vending transaction controller: coin credit, price lookup, dispense handshake, change return.
// Optional idle auto-refund is built when VEND_TIMEOUT_EN is defined.
module vend_ctrl #(
  parameter int MAX_CREDIT = 95,
  parameter int PRICE0     = 15,
  parameter int PRICE1     = 20,
  parameter int PRICE2     = 25,
  parameter int PRICE3     = 30,
  parameter int TIMEOUT    = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] coin,
  input  logic       sel_valid,
  input  logic [1:0] sel,
  input  logic       cancel,
  input  logic       vend_ack,
  output logic       vend_req,
  output logic [1:0] vend_item,
  output logic       change_pulse,
  output logic [6:0] credit,
  output logic       coin_reject,
  output logic       sel_short,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_t;

  state_t state;

  logic       coin_nz;
  logic       coin_legal;
  logic [7:0] credit_sum;
  logic [6:0] sel_price;
  logic       coin_fits;
  logic       price_ok;

  assign coin_nz    = (coin != 5'd0);
  assign coin_legal = (coin == 5'd5) || (coin == 5'd10) || (coin == 5'd25);

  // Widened to 8 bits so credit + coin near the ceiling cannot wrap.
  assign credit_sum = {1'b0, credit} + {3'b000, coin};
  assign coin_fits  = (credit_sum <= 8'(MAX_CREDIT));

  always_comb begin
    sel_price = 7'(PRICE0);
    case (sel)
      2'd0: sel_price = 7'(PRICE0);
      2'd1: sel_price = 7'(PRICE1);
      2'd2: sel_price = 7'(PRICE2);
      2'd3: sel_price = 7'(PRICE3);
      default: sel_price = 7'(PRICE0);
    endcase
  end

  assign price_ok = ({1'b0, credit} >= {1'b0, sel_price});

`ifdef VEND_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;
`endif

  // NOTE: all state and outputs update with non-blocking assignments in one clocked block,
  // so every output is registered and there is no combinational path from inputs to outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      credit       <= 7'd0;
      vend_req     <= 1'b0;
      vend_item    <= 2'd0;
      change_pulse <= 1'b0;
      coin_reject  <= 1'b0;
      sel_short    <= 1'b0;
      busy         <= 1'b0;
`ifdef VEND_TIMEOUT_EN
      tmo_cnt      <= '0;
`endif
    end else begin
      coin_reject  <= 1'b0;
      sel_short    <= 1'b0;
      change_pulse <= 1'b0;

      case (state)
        IDLE: begin
          if (coin_legal) begin
            credit <= 7'(coin);
            state  <= CREDIT;
`ifdef VEND_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end else if (coin_nz) begin
            coin_reject <= 1'b1;
          end
          if (sel_valid) sel_short <= 1'b1;
        end

        CREDIT: begin
          if (cancel) begin
            coin_reject <= coin_nz;
            state       <= CHANGE;
            busy        <= 1'b1;
          end else if (sel_valid) begin
            // A coin arriving with a selection is never folded in, even if the selection is refused.
            coin_reject <= coin_nz;
            if (price_ok) begin
              credit    <= credit - sel_price;
              vend_item <= sel;
              vend_req  <= 1'b1;
              busy      <= 1'b1;
              state     <= VEND;
            end else begin
              sel_short <= 1'b1;
`ifdef VEND_TIMEOUT_EN
              tmo_cnt   <= '0;
`endif
            end
          end else if (coin_legal && coin_fits) begin
            credit <= credit_sum[6:0];
`ifdef VEND_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end else begin
            coin_reject <= coin_nz;
`ifdef VEND_TIMEOUT_EN
            if (tmo_cnt == TW'(TIMEOUT - 1)) begin
              state <= CHANGE;
              busy  <= 1'b1;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
`endif
          end
        end

        VEND: begin
          coin_reject <= coin_nz;
          if (vend_ack) begin
            vend_req <= 1'b0;
            if (credit != 7'd0) begin
              state <= CHANGE;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        CHANGE: begin
          coin_reject  <= coin_nz;
          change_pulse <= 1'b1;
          if (credit <= 7'd5) begin
            credit <= 7'd0;
            state  <= IDLE;
            busy   <= 1'b0;
          end else begin
            credit <= credit - 7'd5;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl: purchases, change return, coin/selection refusal, reset mid-refund.
// Runs the auto-refund scenario when VEND_TIMEOUT_EN is defined, the credit-hold scenario otherwise.
module tb_vend_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] coin;
  logic       sel_valid;
  logic [1:0] sel;
  logic       cancel;
  logic       vend_ack;
  logic       vend_req;
  logic [1:0] vend_item;
  logic       change_pulse;
  logic [6:0] credit;
  logic       coin_reject;
  logic       sel_short;
  logic       busy;

  int checks = 0;
  int errors = 0;

  vend_ctrl #(.TIMEOUT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .coin         (coin),
    .sel_valid    (sel_valid),
    .sel          (sel),
    .cancel       (cancel),
    .vend_ack     (vend_ack),
    .vend_req     (vend_req),
    .vend_item    (vend_item),
    .change_pulse (change_pulse),
    .credit       (credit),
    .coin_reject  (coin_reject),
    .sel_short    (sel_short),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, let the edge sample them, then look 1 ns after the edge.
  task automatic tick(input int c = 0, input bit sv = 0, input int s = 0,
                      input bit cn = 0, input bit ack = 0);
    coin      = 5'(c);
    sel_valid = sv;
    sel       = 2'(s);
    cancel    = cn;
    vend_ack  = ack;
    @(posedge clk);
    #1;
    coin      = 5'd0;
    sel_valid = 1'b0;
    sel       = 2'd0;
    cancel    = 1'b0;
    vend_ack  = 1'b0;
  endtask

  // Idle for a fixed budget of cycles, counting change pulses.
  task automatic count_pulses(input int budget, output int n);
    n = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (change_pulse) n++;
    end
  endtask

  int n;

  initial begin
    rst = 1'b0;
    coin = 5'd0; sel_valid = 1'b0; sel = 2'd0; cancel = 1'b0; vend_ack = 1'b0;
    tick(); tick();
    check("rst_credit", credit, 0);
    check("rst_vend_req", vend_req, 0);
    check("rst_item", vend_item, 0);
    check("rst_pulse", change_pulse, 0);
    check("rst_busy", busy, 0);
    check("rst_rej", coin_reject, 0);
    check("rst_short", sel_short, 0);
    rst = 1'b1;

    // IDLE: selection refused, cancel ignored, illegal coin rejected
    tick(0, 1, 2);
    check("idle_sel_short", sel_short, 1);
    tick(0, 0, 0, 1);
    check("idle_cancel_busy", busy, 0);
    check("idle_sel_short_clr", sel_short, 0);
    tick(3);
    check("idle_bad_coin", coin_reject, 1);
    check("idle_bad_coin_credit", credit, 0);

    // Exact-price purchase, ack in third VEND cycle
    tick(10);
    check("t1_credit10", credit, 10);
    tick(10);
    check("t1_credit20", credit, 20);
    tick(0, 1, 1);
    check("t1_req1", vend_req, 1);
    check("t1_item", vend_item, 1);
    check("t1_credit0", credit, 0);
    check("t1_busy", busy, 1);
    tick(5);
    check("t1_req2", vend_req, 1);
    check("t1_vend_coin_rej", coin_reject, 1);
    tick();
    check("t1_req3", vend_req, 1);
    check("t1_item_stable", vend_item, 1);
    tick(0, 0, 0, 0, 1);
    check("t1_req_fall", vend_req, 0);
    check("t1_busy_clr", busy, 0);
    count_pulses(4, n);
    check("t1_no_change", n, 0);

    // Purchase with 20 change
    tick(25);
    tick(10);
    check("t2_credit35", credit, 35);
    tick(0, 1, 0);
    check("t2_credit20", credit, 20);
    check("t2_item", vend_item, 0);
    tick(0, 0, 0, 0, 1);
    check("t2_req_fall", vend_req, 0);
    check("t2_busy_change", busy, 1);
    check("t2_no_pulse_yet", change_pulse, 0);
    tick();
    check("t2_p1", change_pulse, 1);
    check("t2_c15", credit, 15);
    count_pulses(8, n);
    check("t2_pulses", n + 1, 4);
    check("t2_credit_end", credit, 0);
    check("t2_busy_end", busy, 0);

    // Ceiling overflow and illegal coin
    tick(25); tick(25); tick(25);
    check("t3_credit75", credit, 75);
    tick(25);
    check("t3_over_rej", coin_reject, 1);
    check("t3_credit_hold", credit, 75);
    tick(7);
    check("t3_bad_rej", coin_reject, 1);
    check("t3_credit_hold2", credit, 75);
    tick(5);
    check("t3_rej_clr", coin_reject, 0);
    tick(10);
    check("t3_exact_ceiling", credit, 90);
    tick(5);
    check("t3_at_95", credit, 95);
    tick(5);
    check("t3_over95_rej", coin_reject, 1);
    tick(0, 0, 0, 1);
    count_pulses(25, n);
    check("t3_pulses", n, 19);
    check("t3_credit_end", credit, 0);

    // Short selection, then cancel with a simultaneous coin
    tick(10); tick(5);
    tick(0, 1, 3);
    check("t4_short", sel_short, 1);
    check("t4_credit", credit, 15);
    check("t4_not_busy", busy, 0);
    tick(5, 0, 0, 1);
    check("t4_cancel_rej", coin_reject, 1);
    check("t4_credit_kept", credit, 15);
    check("t4_busy", busy, 1);
    count_pulses(6, n);
    check("t4_pulses", n, 3);

    // Reset during the second CHANGE cycle of a 4-pulse refund
    tick(10); tick(10);
    tick(0, 0, 0, 1);
    tick();
    check("t5_p1", change_pulse, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("t5_rst_pulse", change_pulse, 0);
    check("t5_rst_credit", credit, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_req", vend_req, 0);
    count_pulses(6, n);
    check("t5_no_pulses", n, 0);

`ifdef VEND_TIMEOUT_EN
    tick(10);
    for (int i = 0; i < 7; i++) tick();
    check("t6_still_credit", busy, 0);
    tick();
    check("t6_timeout_change", busy, 1);
    count_pulses(5, n);
    check("t6_pulses", n, 2);
`else
    tick(10);
    for (int i = 0; i < 100; i++) tick();
    check("t6_hold_credit", credit, 10);
    check("t6_hold_busy", busy, 0);
    tick(0, 0, 0, 1);
    count_pulses(5, n);
    check("t6_pulses", n, 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
